// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: clears x1..NUM_REGS-1 after reset, then arbitrates
// pipeline writeback (A) against buffered multi-cycle results (B). Option: RWC_STARVE_GUARD_EN.
module rf_wb_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_REGS     = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              RWC_CLK,
  input  logic              RWC_RST,
  input  logic              RWC_A_EN,
  input  logic [ADDR_W-1:0] RWC_A_WA,
  input  logic [DATA_W-1:0] RWC_A_WD,
  input  logic              RWC_B_VALID,
  input  logic [ADDR_W-1:0] RWC_B_WA,
  input  logic [DATA_W-1:0] RWC_B_WD,
  output logic              RWC_B_READY,
  output logic              RWC_RF_EN,
  output logic [ADDR_W-1:0] RWC_RF_WA,
  output logic [DATA_W-1:0] RWC_RF_WD,
  output logic              RWC_BUSY,
  output logic              RWC_B_PEND,
  output logic              RWC_A_STALL
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] fifo_wa [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              vld_p1;
  logic [ADDR_W-1:0] wa_p1;
  logic [DATA_W-1:0] wd_p1;

  logic run, full, empty, a_req, push, pop, a_stall;

  always_comb begin
    run   = (state == ST_RUN);
    full  = (count == DEPTH_C);
    empty = (count == '0);
    a_req = RWC_A_EN && (RWC_A_WA != '0);
    push  = RWC_B_VALID && run && !full;
    pop   = run && !empty && (!a_req || a_stall);
  end

`ifdef RWC_STARVE_GUARD_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  logic [AGE_W-1:0] age;

  assign a_stall = (age == AGE_W'(STARVE_LIMIT));

  always_ff @(posedge RWC_CLK) begin
    if (RWC_RST || !run || empty || pop) age <= '0;
    else                                 age <= age + 1'b1;
  end
`else
  // Guard compiled out: A never stalls.
  assign a_stall = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge RWC_CLK) begin
    if (push) begin
      fifo_wa[wr_ptr] <= RWC_B_WA;
      fifo_wd[wr_ptr] <= RWC_B_WD;
    end
  end

  // p0 -> p1: source selection into the registered RF write port
  always_ff @(posedge RWC_CLK) begin
    if (RWC_RST) begin
      state   <= ST_CLEAR;
      clr_cnt <= ADDR_W'(1);
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      wa_p1   <= '0;
      wd_p1   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          vld_p1  <= 1'b1;
          wa_p1   <= clr_cnt;
          wd_p1   <= '0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_REG) state <= ST_RUN;
        end
        default: begin
          if (a_req && !a_stall) begin
            vld_p1 <= 1'b1;
            wa_p1  <= RWC_A_WA;
            wd_p1  <= RWC_A_WD;
          end else if (!empty) begin
            vld_p1 <= (fifo_wa[rd_ptr] != '0);
            wa_p1  <= fifo_wa[rd_ptr];
            wd_p1  <= fifo_wd[rd_ptr];
          end else begin
            vld_p1 <= 1'b0;
          end
        end
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign RWC_RF_EN   = vld_p1;
  assign RWC_RF_WA   = wa_p1;
  assign RWC_RF_WD   = wd_p1;
  assign RWC_BUSY    = !run;
  assign RWC_B_READY = run && !full;
  assign RWC_B_PEND  = !empty;
  assign RWC_A_STALL = a_stall;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: vector table with a B-side scoreboard plus
// hand-written clear, mid-operation reset and starvation sequences.
module tb_rf_wb_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              RWC_CLK = 1'b0;
  logic              RWC_RST;
  logic              RWC_A_EN;
  logic [ADDR_W-1:0] RWC_A_WA;
  logic [DATA_W-1:0] RWC_A_WD;
  logic              RWC_B_VALID;
  logic [ADDR_W-1:0] RWC_B_WA;
  logic [DATA_W-1:0] RWC_B_WD;
  logic              RWC_B_READY;
  logic              RWC_RF_EN;
  logic [ADDR_W-1:0] RWC_RF_WA;
  logic [DATA_W-1:0] RWC_RF_WD;
  logic              RWC_BUSY;
  logic              RWC_B_PEND;
  logic              RWC_A_STALL;

  rf_wb_ctrl dut (
    .RWC_CLK(RWC_CLK), .RWC_RST(RWC_RST),
    .RWC_A_EN(RWC_A_EN), .RWC_A_WA(RWC_A_WA), .RWC_A_WD(RWC_A_WD),
    .RWC_B_VALID(RWC_B_VALID), .RWC_B_WA(RWC_B_WA), .RWC_B_WD(RWC_B_WD),
    .RWC_B_READY(RWC_B_READY), .RWC_RF_EN(RWC_RF_EN), .RWC_RF_WA(RWC_RF_WA),
    .RWC_RF_WD(RWC_RF_WD), .RWC_BUSY(RWC_BUSY), .RWC_B_PEND(RWC_B_PEND),
    .RWC_A_STALL(RWC_A_STALL)
  );

  always #5 RWC_CLK = ~RWC_CLK;

  typedef struct {
    logic              a_en;
    logic [ADDR_W-1:0] a_wa;
    logic [DATA_W-1:0] a_wd;
    logic              b_v;
    logic [ADDR_W-1:0] b_wa;
    logic [DATA_W-1:0] b_wd;
    logic              e_en;
    logic              e_rdy;
    logic              e_pend;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wr_t;

  vec_t vt[15];
  wr_t  sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge RWC_CLK);
    #1;
  endtask

  task automatic drive(input logic a_en, input logic [ADDR_W-1:0] a_wa, input logic [DATA_W-1:0] a_wd,
                       input logic b_v, input logic [ADDR_W-1:0] b_wa, input logic [DATA_W-1:0] b_wd);
    RWC_A_EN = a_en;  RWC_A_WA = a_wa;  RWC_A_WD = a_wd;
    RWC_B_VALID = b_v; RWC_B_WA = b_wa; RWC_B_WD = b_wd;
  endtask

  task automatic run_clear();
    for (int i = 1; i <= 31; i++) begin
      step();
      chk("clr_en", RWC_RF_EN, 1);
      chk("clr_wa", RWC_RF_WA, i);
      chk("clr_wd", RWC_RF_WD, 0);
      chk("clr_busy", RWC_BUSY, (i != 31));
      chk("clr_ready", RWC_B_READY, (i == 31));
    end
  endtask

  initial begin
    logic rdy_prev;
    wr_t  e;

    //            a_en  a_wa   a_wd            b_v   b_wa   b_wd            en    rdy   pend
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 5'd0,  32'h00000055, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h00001234, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 5'd3,  32'h000000A3, 1'b1, 5'd10, 32'h00000B10, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 5'd3,  32'h000000A3, 1'b1, 5'd11, 32'h00000B11, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 5'd3,  32'h000000A3, 1'b1, 5'd12, 32'h00000B12, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000099, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd20, 32'h00000020, 1'b0, 1'b1, 1'b1};
    vt[12] = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd21, 32'h00000021, 1'b1, 1'b1, 1'b1};
    vt[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};

    drive(0, 0, 0, 0, 0, 0);
    RWC_RST = 1'b1;
    step();
    step();
    chk("rst_busy", RWC_BUSY, 1);
    chk("rst_ready", RWC_B_READY, 0);
    chk("rst_pend", RWC_B_PEND, 0);
    chk("rst_en", RWC_RF_EN, 0);
    chk("rst_wa", RWC_RF_WA, 0);
    chk("rst_wd", RWC_RF_WD, 0);
    chk("rst_stall", RWC_A_STALL, 0);

    // A requests during the clear must be dropped
    RWC_RST = 1'b0;
    drive(1, 5'd9, 32'h99999999, 0, 0, 0);
    run_clear();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("idle_en", RWC_RF_EN, 0);
    chk("idle_wa_hold", RWC_RF_WA, 31);

    rdy_prev = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].a_en, vt[i].a_wa, vt[i].a_wd, vt[i].b_v, vt[i].b_wa, vt[i].b_wd);
      if (vt[i].b_v && rdy_prev && vt[i].b_wa != '0)
        sbq.push_back('{vt[i].b_wa, vt[i].b_wd});
      step();
      chk($sformatf("v%0d_en", i), RWC_RF_EN, vt[i].e_en);
      chk($sformatf("v%0d_ready", i), RWC_B_READY, vt[i].e_rdy);
      chk($sformatf("v%0d_pend", i), RWC_B_PEND, vt[i].e_pend);
      chk($sformatf("v%0d_stall", i), RWC_A_STALL, 0);
      if (vt[i].a_en && vt[i].a_wa != '0) begin
        chk($sformatf("v%0d_a_wa", i), RWC_RF_WA, vt[i].a_wa);
        chk($sformatf("v%0d_a_wd", i), RWC_RF_WD, vt[i].a_wd);
      end else if (RWC_RF_EN) begin
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_underflow", i), 0, 1);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_b_wa", i), RWC_RF_WA, e.wa);
          chk($sformatf("v%0d_b_wd", i), RWC_RF_WD, e.wd);
        end
      end
      rdy_prev = vt[i].e_rdy;
    end
    chk("sb_drained", sbq.size(), 0);

    // Fill the FIFO behind a busy A, then reset
    drive(1, 5'd3, 32'h33, 1, 5'd13, 32'hD13);
    step();
    drive(1, 5'd3, 32'h33, 1, 5'd14, 32'hD14);
    step();
    chk("full_pend", RWC_B_PEND, 1);
    chk("full_ready", RWC_B_READY, 0);
    drive(0, 0, 0, 0, 0, 0);
    RWC_RST = 1'b1;
    step();
    chk("mrst_pend", RWC_B_PEND, 0);
    chk("mrst_busy", RWC_BUSY, 1);
    chk("mrst_ready", RWC_B_READY, 0);
    chk("mrst_en", RWC_RF_EN, 0);
    RWC_RST = 1'b0;
    run_clear();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("mrst_pend_after", RWC_B_PEND, 0);

`ifdef RWC_STARVE_GUARD_EN
    drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
    step();
    chk("sg_first_wa", RWC_RF_WA, 4);
    chk("sg_first_pend", RWC_B_PEND, 1);
    drive(1, 5'd4, 32'h44, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("sg_wait%0d_stall", k), RWC_A_STALL, 0);
      chk($sformatf("sg_wait%0d_wa", k), RWC_RF_WA, 4);
    end
    step();
    chk("sg_stall", RWC_A_STALL, 1);
    step();
    chk("sg_b_en", RWC_RF_EN, 1);
    chk("sg_b_wa", RWC_RF_WA, 6);
    chk("sg_b_wd", RWC_RF_WD, 32'h66);
    chk("sg_b_stall", RWC_A_STALL, 0);
    step();
    chk("sg_a_en", RWC_RF_EN, 1);
    chk("sg_a_wa", RWC_RF_WA, 4);
    chk("sg_a_wd", RWC_RF_WD, 32'h44);
`else
    drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
    step();
    drive(1, 5'd4, 32'h44, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("ng%0d_stall", k), RWC_A_STALL, 0);
      chk($sformatf("ng%0d_wa", k), RWC_RF_WA, 4);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("ng_b_wa", RWC_RF_WA, 6);
    chk("ng_b_wd", RWC_RF_WD, 32'h66);
`endif
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
